// File: rtl/uart_tx_feeder.sv
// Host-side byte FIFO feeding the UART TX core through its Data_Valid / P_DATA / busy handshake.
// One byte is launched at a time, and only while the TX core reports idle.
module uart_tx_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     ovf_clr,
  input  logic                     busy,
  output logic [DATA_WIDTH-1:0]    P_DATA,
  output logic                     Data_Valid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   LVL_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0]   LVL_FULL = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wrPtr_q, wrPtr_d;
  logic [ADDR_WIDTH-1:0]   rdPtr_q, rdPtr_d;
  logic [ADDR_WIDTH:0]     level_q, level_d;
  logic                    overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0]   pData_q, pData_d;
  logic                    dataValid_q, dataValid_d;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic launch;
  logic wrAccept;

  assign full       = (level_q == LVL_FULL);
  assign empty      = (level_q == '0);
  assign level      = level_q;
  assign overflow   = overflow_q;
  assign P_DATA     = pData_q;
  assign Data_Valid = dataValid_q;

  // A launch is the only pop; a full FIFO can still take a write on that same edge.
  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && !busy) begin
          launch  = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH:    state_d = WAIT_BUSY;
      WAIT_BUSY: if (busy)  state_d = WAIT_DONE;
      WAIT_DONE: if (!busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    wrAccept = wr_en && (!full || launch);

    wrPtr_d = wrAccept ? (wrPtr_q + PTR_ONE) : wrPtr_q;
    rdPtr_d = launch   ? (rdPtr_q + PTR_ONE) : rdPtr_q;

    level_d = level_q;
    case ({wrAccept, launch})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    overflow_d = overflow_q;
    if (ovf_clr)             overflow_d = 1'b0;
    if (wr_en && !wrAccept)  overflow_d = 1'b1;

    pData_d     = launch ? mem[rdPtr_q] : pData_q;
    dataValid_d = launch;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      pData_q     <= '0;
      dataValid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      pData_q     <= pData_d;
      dataValid_q <= dataValid_d;
    end
  end

  // Storage is left uncleared by reset; the level counter alone decides what is valid.
  always_ff @(posedge CLK) begin
    if (wrAccept) mem[wrPtr_q] <= wr_data;
  end

endmodule
